aer_event_decoder: RTL and testbench

- Parametrised AER input stage for the neural accelerator: unpacks {channel, timestamp} words from the AER link and buffers them in a FIFO.
- Presents events to the core over a ready/valid interface.
- Adds a per-channel enable mask, timestamp wrap detection, an overflow flag and a drop counter.
- Sits between the AER receiver and the neuron/spike-routing logic.

---
 rtl/aer_event_decoder.sv | 136 +++++++++++++
 tb/tb_aer_event_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_event_decoder.sv
// AER input stage: unpacks {channel, timestamp} words, filters by channel mask, buffers in a FWFT FIFO.
// Data is visible one cycle after accept; aer_ready comes from the registered count, so a pop frees the slot one cycle later.
module aer_event_decoder #(
  parameter int CH_W       = 4,
  parameter int TS_W       = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_W+TS_W-1:0]   aer_in,
  input  logic                   aer_valid,
  output logic                   aer_ready,
  input  logic [(1<<CH_W)-1:0]   channel_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH_W-1:0]        channel_id,
  output logic [TS_W-1:0]        timestamp,
  output logic                   spike_detected,
  output logic                   ts_wrap,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [TS_W-1:0] ts;
  } aer_ev_t;

  aer_ev_t           mem_q [FIFO_DEPTH];
  aer_ev_t           ev_in;
  aer_ev_t           head_ev;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TS_W-1:0]   prev_ts_q, prev_ts_d;
  logic              first_q, first_d;
  logic              spike_q, spike_d;
  logic              wrap_q, wrap_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  aer_ev_t           hold_ev_q, hold_ev_d;

  logic              accept;
  logic              ch_en;
  logic              push;
  logic              drop;
  logic              pop;

  assign ev_in     = aer_ev_t'(aer_in);
  assign head_ev   = mem_q[rd_ptr_q];
  assign aer_ready = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  // When empty, present the last popped entry so the outputs hold their values.
  assign channel_id     = out_valid ? head_ev.ch : hold_ev_q.ch;
  assign timestamp      = out_valid ? head_ev.ts : hold_ev_q.ts;
  assign spike_detected = spike_q;
  assign ts_wrap        = wrap_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_q;

  always_comb begin
    accept     = aer_valid && aer_ready;
    ch_en      = channel_mask[ev_in.ch];
    push       = accept && ch_en;
    drop       = accept && !ch_en;
    pop        = out_valid && out_ready;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    prev_ts_d  = prev_ts_q;
    first_d    = first_q;
    spike_d    = push;
    wrap_d     = 1'b0;
    overflow_d = overflow_q | (aer_valid && !aer_ready);
    drop_d     = drop_q;
    hold_ev_d  = hold_ev_q;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      prev_ts_d = ev_in.ts;
      first_d   = 1'b0;
      wrap_d    = !first_q && (ev_in.ts < prev_ts_q);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      hold_ev_d = head_ev;
    end

    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      prev_ts_q  <= '0;
      first_q    <= 1'b1;
      spike_q    <= 1'b0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      hold_ev_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      prev_ts_q  <= prev_ts_d;
      first_q    <= first_d;
      spike_q    <= spike_d;
      wrap_q     <= wrap_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      hold_ev_q  <= hold_ev_d;
    end
  end

  // Storage needs no reset: reads are qualified by count.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= ev_in;
    end
  end

endmodule

// File: tb/tb_aer_event_decoder.sv
// Bench for aer_event_decoder: vector table plus hand-written sequences, scoreboard queue for output order.
module tb_aer_event_decoder;

  localparam int CH_W   = 4;
  localparam int TS_W   = 20;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [23:0]       aer_in = '0;
  logic              aer_valid = 1'b0;
  logic              aer_ready;
  logic [15:0]       channel_mask = 16'hFFFF;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        channel_id;
  logic [19:0]       timestamp;
  logic              spike_detected;
  logic              ts_wrap;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  int checks = 0;
  int errors = 0;
  int drop_exp = 0;
  logic [23:0] exp_q [$];

  typedef struct {
    logic [3:0]  ch;
    logic [19:0] ts;
    logic [15:0] mask;
    bit          exp_spike;
    bit          exp_wrap;
  } vec_t;
  vec_t vecs [10];

  aer_event_decoder #(
    .CH_W(CH_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .aer_in(aer_in), .aer_valid(aer_valid),
    .aer_ready(aer_ready), .channel_mask(channel_mask), .out_valid(out_valid),
    .out_ready(out_ready), .channel_id(channel_id), .timestamp(timestamp),
    .spike_detected(spike_detected), .ts_wrap(ts_wrap), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    aer_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    drop_exp = 0;
  endtask

  // Hold aer_valid until accepted; the model decides whether the event is stored or dropped.
  task automatic send(input logic [3:0] ch, input logic [19:0] ts);
    bit done;
    done = 1'b0;
    aer_in = {ch, ts};
    aer_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (aer_ready) begin
        if (channel_mask[ch]) exp_q.push_back({ch, ts});
        else if (drop_exp < (1 << DROP_W) - 1) drop_exp++;
        done = 1'b1;
      end
      tick();
    end
    aer_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: every handshake on the output must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {8'h0, channel_id, timestamp}, 32'hFFFF_FFFF);
      end else begin
        chk("out_data", {8'h0, channel_id, timestamp}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{4'h3, 20'h00100, 16'hFFFF, 1'b1, 1'b0};
    vecs[1] = '{4'h2, 20'h00050, 16'hFFFB, 1'b0, 1'b0};
    vecs[2] = '{4'h5, 20'h00200, 16'hFFFB, 1'b1, 1'b0};
    vecs[3] = '{4'h2, 20'h00060, 16'hFFFB, 1'b0, 1'b0};
    vecs[4] = '{4'h1, 20'hFFFF0, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{4'h1, 20'h00005, 16'hFFFF, 1'b1, 1'b1};
    vecs[6] = '{4'h1, 20'h00005, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{4'h7, 20'h00004, 16'hFFFF, 1'b1, 1'b1};
    vecs[8] = '{4'h2, 20'h00001, 16'hFFFB, 1'b0, 1'b0};
    vecs[9] = '{4'h7, 20'h00006, 16'hFFFF, 1'b1, 1'b0};

    tick();
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_aer_ready", {31'd0, aer_ready}, 32'd1);
    chk("rst_channel_id", {28'd0, channel_id}, 32'd0);
    chk("rst_timestamp", {12'd0, timestamp}, 32'd0);
    chk("rst_spike", {31'd0, spike_detected}, 32'd0);
    chk("rst_wrap", {31'd0, ts_wrap}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {28'd0, drop_count}, 32'd0);

    // Single events: mask filtering and timestamp wrap.
    foreach (vecs[k]) begin
      channel_mask = vecs[k].mask;
      out_ready = 1'b1;
      send(vecs[k].ch, vecs[k].ts);
      chk("vec_spike", {31'd0, spike_detected}, {31'd0, vecs[k].exp_spike});
      chk("vec_wrap", {31'd0, ts_wrap}, {31'd0, vecs[k].exp_wrap});
      chk("vec_out_valid", {31'd0, out_valid}, {31'd0, vecs[k].exp_spike});
      chk("vec_drop", {28'd0, drop_count}, drop_exp);
      tick();
      chk("vec_spike_end", {31'd0, spike_detected}, 32'd0);
      chk("vec_wrap_end", {31'd0, ts_wrap}, 32'd0);
      chk("vec_empty", {31'd0, out_valid}, 32'd0);
    end
    chk("hold_channel", {28'd0, channel_id}, 32'd7);
    chk("hold_timestamp", {12'd0, timestamp}, 32'd6);
    chk("vec_queue_empty", exp_q.size(), 32'd0);

    // Fill under backpressure, then drain.
    do_reset();
    channel_mask = 16'hFFFF;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("fill_ready", {31'd0, aer_ready}, 32'd1);
      send(4'h4, 20'(i));
    end
    chk("full_ready", {31'd0, aer_ready}, 32'd0);
    aer_in = {4'h4, 20'd9};
    aer_valid = 1'b1;
    tick();
    tick();
    chk("full_overflow", {31'd0, overflow}, 32'd1);
    chk("full_ready_hold", {31'd0, aer_ready}, 32'd0);
    chk("full_head_ts", {12'd0, timestamp}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", {31'd0, aer_ready}, 32'd0);
    tick();
    chk("after_pop_ready", {31'd0, aer_ready}, 32'd1);
    send(4'h4, 20'd9);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Simultaneous push and pop with four entries buffered.
    do_reset();
    for (int i = 0; i < 4; i++) send(4'h6, 20'(10 + i));
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("pp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("pp_ready", {31'd0, aer_ready}, 32'd1);
      send(4'h6, 20'(14 + k));
    end
    n = 0;
    while (out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("pp_count", n, 32'd4);
    chk("pp_queue_empty", exp_q.size(), 32'd0);

    // Drop counter saturation.
    do_reset();
    channel_mask = 16'h0000;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(4'(i), 20'(i));
      chk("sat_drop", {28'd0, drop_count}, drop_exp);
    end
    chk("sat_final", {28'd0, drop_count}, 32'd15);
    chk("sat_no_out", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of traffic with the FIFO full and overflow set.
    do_reset();
    channel_mask = 16'hFFFB;
    send(4'h2, 20'h00010);
    for (int i = 1; i <= DEPTH; i++) send(4'h1, 20'(i * 256));
    aer_in = {4'h1, 20'h00900};
    aer_valid = 1'b1;
    tick();
    chk("pre_rst_overflow", {31'd0, overflow}, 32'd1);
    chk("pre_rst_drop", {28'd0, drop_count}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_drop", {28'd0, drop_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, aer_ready}, 32'd1);
    rst_n = 1'b1;
    aer_valid = 1'b0;
    exp_q.delete();
    drop_exp = 0;
    channel_mask = 16'hFFFF;
    out_ready = 1'b1;
    send(4'h1, 20'h00001);
    chk("post_rst_spike", {31'd0, spike_detected}, 32'd1);
    chk("post_rst_wrap", {31'd0, ts_wrap}, 32'd0);
    tick();
    chk("post_rst_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
